// File: rtl/turing_machine_param.sv
// ---------------------------------------------------------------------------
// turing_machine_param
//
// Purpose:
//   Parametrised single-tape Turing machine with a 2**SW-symbol alphabet,
//   NS states and a TL-cell tape.
//   - Loading happens over a valid/ready stream: the transition table first,
//     then the tape contents.
//   - Execution runs one transition per rising edge of step, or free-runs
//     while run is high.
//   - A window of WIN cells centred on the head is exposed for display.
//
// Ports:
//   clock       in   1       system clock
//   reset       in   1       asynchronous, active-high reset
//   load_valid  in   1       load word present
//   load_data   in   EW      table entry {next_state,write_sym,move} or tape symbol [SW-1:0]
//   load_ready  out  1       load word accepted this cycle
//   step        in   1       level input; each rising edge in READY requests one transition
//   run         in   1       free-run while high
//   cur_state   out  SB      current machine state
//   head_pos    out  HB      current head index
//   window_out  out  WIN*SW  cells head-(WIN-1)/2 .. head+(WIN-1)/2, lowest index in LSBs
//   halted      out  1       halt transition executed
//   fault       out  1       head tried to move off the tape
//   done        out  1       halted | fault
//   step_count  out  16      executed transitions
//
// Move encoding: 00 stay, 01 right, 10 left, 11 halt.
//
// Build option:
//   TM_STEP_COUNT_EN  when defined, step_count is a saturating 16-bit counter
//                     of executed transitions; otherwise step_count reads 0.
// ---------------------------------------------------------------------------
module turing_machine_param #(
    parameter int unsigned SW    = 2,
    parameter int unsigned NS    = 4,
    parameter int unsigned TL    = 16,
    parameter int unsigned HEAD0 = 0,
    parameter int unsigned WIN   = 5,
    localparam int unsigned SB   = $clog2(NS),
    localparam int unsigned HB   = $clog2(TL),
    localparam int unsigned EW   = SB + SW + 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_valid,
    input  logic [EW-1:0]     load_data,
    output logic              load_ready,
    input  logic              step,
    input  logic              run,
    output logic [SB-1:0]     cur_state,
    output logic [HB-1:0]     head_pos,
    output logic [WIN*SW-1:0] window_out,
    output logic              halted,
    output logic              fault,
    output logic              done,
    output logic [15:0]       step_count
);

    localparam int unsigned NE   = NS * (2 ** SW);
    localparam int unsigned IXB  = SB + SW;
    localparam int unsigned MAXN = (NE > TL) ? NE : TL;
    localparam int unsigned IW   = $clog2(MAXN);
    localparam int unsigned HALF = (WIN - 1) / 2;

    typedef enum logic [2:0] {
        S_LOAD_TABLE,
        S_LOAD_TAPE,
        S_READY,
        S_FETCH,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_e;

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [SB-1:0]   mstate_q, mstate_d;
    logic [HB-1:0]   head_q, head_d;
    logic [EW-1:0]   entry_q, entry_d;
    logic            halted_q, halted_d;
    logic            fault_q, fault_d;
    logic            step_prev_q;

    // Storage is not reset: a reset returns to loading without wiping contents.
    logic [EW-1:0]   table_q [NE];
    logic [SW-1:0]   tape_q  [TL];

    logic            tbl_we;
    logic            tape_we;
    logic [HB-1:0]   tape_waddr;
    logic [SW-1:0]   tape_wdata;
    logic            cnt_inc;

    logic            step_rise;
    logic [SW-1:0]   cur_sym;
    logic [EW-1:0]   tbl_rd;
    logic [SB-1:0]   ent_next;
    logic [SW-1:0]   ent_sym;
    logic [1:0]      ent_move;

    assign step_rise = step && !step_prev_q;
    assign cur_sym   = tape_q[head_q];
    assign tbl_rd    = table_q[{mstate_q, cur_sym}];
    assign ent_next  = entry_q[EW-1 -: SB];
    assign ent_sym   = entry_q[2 +: SW];
    assign ent_move  = entry_q[1:0];

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_LOAD_TABLE;
            idx_q       <= '0;
            mstate_q    <= '0;
            head_q      <= HB'(HEAD0);
            entry_q     <= '0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mstate_q    <= mstate_d;
            head_q      <= head_d;
            entry_q     <= entry_d;
            halted_q    <= halted_d;
            fault_q     <= fault_d;
            step_prev_q <= step;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mstate_d   = mstate_q;
        head_d     = head_q;
        entry_d    = entry_q;
        halted_d   = halted_q;
        fault_d    = fault_q;
        tbl_we     = 1'b0;
        tape_we    = 1'b0;
        tape_waddr = head_q;
        tape_wdata = ent_sym;
        cnt_inc    = 1'b0;

        unique case (state_q)
            S_LOAD_TABLE: begin
                if (load_valid) begin
                    tbl_we = 1'b1;
                    if (idx_q == IW'(NE - 1)) begin
                        idx_d   = '0;
                        state_d = S_LOAD_TAPE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_LOAD_TAPE: begin
                if (load_valid) begin
                    tape_we    = 1'b1;
                    tape_waddr = idx_q[HB-1:0];
                    tape_wdata = load_data[SW-1:0];
                    if (idx_q == IW'(TL - 1)) begin
                        idx_d   = '0;
                        state_d = S_READY;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end
            end
            S_READY: begin
                if (run || step_rise) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                entry_d = tbl_rd;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Write and state update happen even when the move faults.
                tape_we  = 1'b1;
                mstate_d = ent_next;
                cnt_inc  = 1'b1;
                state_d  = S_READY;
                case (ent_move)
                    2'b11: begin
                        halted_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    2'b10: begin
                        if (head_q == '0) begin
                            fault_d = 1'b1;
                            state_d = S_FAULT;
                        end else begin
                            head_d = head_q - HB'(1);
                        end
                    end
                    2'b01: begin
                        if (head_q == HB'(TL - 1)) begin
                            fault_d = 1'b1;
                            state_d = S_FAULT;
                        end else begin
                            head_d = head_q + HB'(1);
                        end
                    end
                    default: ;
                endcase
            end
            S_HALT, S_FAULT: ;
            default: state_d = S_LOAD_TABLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Table and tape storage
    // -----------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset && tbl_we) begin
            table_q[idx_q[IXB-1:0]] <= load_data;
        end
        if (!reset && tape_we) begin
            tape_q[tape_waddr] <= tape_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Display window; cells off either end of the tape read as symbol 0
    // -----------------------------------------------------------------------
    int pos;
    always_comb begin
        window_out = '0;
        pos        = 0;
        for (int unsigned i = 0; i < WIN; i++) begin
            pos = int'(head_q) + int'(i) - int'(HALF);
            if (pos >= 0 && pos < int'(TL)) begin
                window_out[i*SW +: SW] = tape_q[pos[HB-1:0]];
            end
        end
    end

    // -----------------------------------------------------------------------
    // Transition counter
    // -----------------------------------------------------------------------
`ifdef TM_STEP_COUNT_EN
    logic [15:0] cnt_q;
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (cnt_inc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end
    assign step_count = cnt_q;
`else
    logic unused_cnt_inc;
    assign unused_cnt_inc = cnt_inc;
    assign step_count     = '0;
`endif

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign load_ready = (state_q == S_LOAD_TABLE) || (state_q == S_LOAD_TAPE);
    assign cur_state  = mstate_q;
    assign head_pos   = head_q;
    assign halted     = halted_q;
    assign fault      = fault_q;
    assign done       = halted_q | fault_q;

endmodule

// File: tb/tb_turing_machine_param.sv
module tb_turing_machine_param;

    localparam int SW  = 2;
    localparam int NS  = 4;
    localparam int TL  = 16;
    localparam int WIN = 5;
    localparam int EW  = 6;

    logic              clock = 1'b0;
    logic              reset;
    logic              load_valid;
    logic [EW-1:0]     load_data;
    logic              load_ready;
    logic              step;
    logic              run;
    logic [1:0]        cur_state;
    logic [3:0]        head_pos;
    logic [WIN*SW-1:0] window_out;
    logic              halted;
    logic              fault;
    logic              done;
    logic [15:0]       step_count;

    turing_machine_param #(
        .SW(SW), .NS(NS), .TL(TL), .HEAD0(0), .WIN(WIN)
    ) dut (
        .clock(clock), .reset(reset),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .step(step), .run(run),
        .cur_state(cur_state), .head_pos(head_pos), .window_out(window_out),
        .halted(halted), .fault(fault), .done(done), .step_count(step_count)
    );

    always #5 clock = ~clock;

    localparam int F_READY = 0, F_STATE = 1, F_HEAD = 2, F_HALT = 3,
                   F_FAULT = 4, F_DONE = 5, F_CNT = 6, F_WIN = 7;

    typedef struct {
        string       name;
        int          fld;
        logic [31:0] exp;
        logic [31:0] mask;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   req_cnt    = 0;
    int   ack_cnt    = 0;

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef TM_STEP_COUNT_EN
        return 32'(n);
`else
        return 32'(0 * n);
`endif
    endfunction

    function automatic logic [31:0] actual(input int fld);
        case (fld)
            F_READY: return 32'(load_ready);
            F_STATE: return 32'(cur_state);
            F_HEAD:  return 32'(head_pos);
            F_HALT:  return 32'(halted);
            F_FAULT: return 32'(fault);
            F_DONE:  return 32'(done);
            F_CNT:   return 32'(step_count);
            F_WIN:   return 32'(window_out);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: on each sample request, pop every queued expectation and compare.
    initial begin
        exp_t        e;
        logic [31:0] a;
        forever begin
            @(negedge clock);
            if (ack_cnt != req_cnt) begin
                while (sb.size() > 0) begin
                    e = sb.pop_front();
                    a = actual(e.fld) & e.mask;
                    compared++;
                    if (a !== (e.exp & e.mask)) begin
                        mismatched++;
                        $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, a, e.exp & e.mask);
                    end
                end
                ack_cnt = req_cnt;
            end
        end
    end

    task automatic sb_push(input string name, input int fld, input logic [31:0] exp,
                           input logic [31:0] mask = 32'hFFFF_FFFF);
        exp_t e;
        e.name = name; e.fld = fld; e.exp = exp; e.mask = mask;
        sb.push_back(e);
    endtask

    task automatic check_now();
        req_cnt++;
        @(negedge clock);
        #1;
        if (ack_cnt != req_cnt) begin
            compared++;
            mismatched++;
            $display("FAIL monitor_timeout: got ack %0d, expected %0d", ack_cnt, req_cnt);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; load_valid = 1'b0; step = 1'b0; run = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic load_word(input logic [EW-1:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    // st0 holds state-0 entries (symbol y at [6y+:6]); other states halt in place.
    // tape packs cell i at [2i+:2].
    task automatic load_prog(input logic [23:0] st0, input logic [31:0] tape);
        for (int i = 0; i < 16; i++) begin
            if (i < 4) load_word(st0[i*6 +: 6]);
            else       load_word(6'h03);
        end
        for (int i = 0; i < 16; i++) begin
            load_word({4'b0, tape[i*2 +: 2]});
        end
    endtask

    task automatic wait_done(input int max);
        for (int k = 0; k < max; k++) begin
            if (done) break;
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; load_valid = 1'b0; load_data = '0; step = 1'b0; run = 1'b0;
        do_reset();

        // Reset values; tape contents unknown, so only the off-tape cells are fixed.
        sb_push("rst_ready", F_READY, 1);
        sb_push("rst_state", F_STATE, 0);
        sb_push("rst_head",  F_HEAD,  0);
        sb_push("rst_done",  F_DONE,  0);
        sb_push("rst_halt",  F_HALT,  0);
        sb_push("rst_fault", F_FAULT, 0);
        sb_push("rst_cnt",   F_CNT,   0);
        sb_push("rst_winlo", F_WIN,   0, 32'h0000_000F);
        check_now();

        // Write 1 and move right until the 3 at cell 5 halts.
        load_prog({6'h0F, 6'h05, 6'h05, 6'h05}, 32'h0000_0C00);
        sb_push("ld_ready", F_READY, 0);
        sb_push("ld_head",  F_HEAD,  0);
        sb_push("ld_win",   F_WIN,   0);
        check_now();
        run = 1'b1;
        wait_done(100);
        sb_push("halt_halted", F_HALT,  1);
        sb_push("halt_fault",  F_FAULT, 0);
        sb_push("halt_done",   F_DONE,  1);
        sb_push("halt_head",   F_HEAD,  5);
        sb_push("halt_state",  F_STATE, 0);
        sb_push("halt_cnt",    F_CNT,   exp_cnt(6));
        sb_push("halt_win",    F_WIN,   32'h035);
        check_now();

        // Terminal state ignores step, run and load words.
        run = 1'b0; step = 1'b1; load_valid = 1'b1; load_data = 6'h00;
        repeat (5) tick();
        step = 1'b0; load_valid = 1'b0;
        tick();
        sb_push("term_head",  F_HEAD,  5);
        sb_push("term_halt",  F_HALT,  1);
        sb_push("term_cnt",   F_CNT,   exp_cnt(6));
        sb_push("term_win",   F_WIN,   32'h035);
        sb_push("term_ready", F_READY, 0);
        check_now();

        // Reset keeps the tape: window shows cells 0..2 = 1 in the upper cells.
        do_reset();
        sb_push("rst2_ready", F_READY, 1);
        sb_push("rst2_head",  F_HEAD,  0);
        sb_push("rst2_done",  F_DONE,  0);
        sb_push("rst2_halt",  F_HALT,  0);
        sb_push("rst2_state", F_STATE, 0);
        sb_push("rst2_cnt",   F_CNT,   0);
        sb_push("rst2_win",   F_WIN,   32'h150);
        check_now();

        // Move left off cell 0 -> fault, write and state update still happen.
        load_prog({4{6'h2A}}, 32'h0);
        run = 1'b1;
        wait_done(100);
        run = 1'b0;
        sb_push("flt_fault", F_FAULT, 1);
        sb_push("flt_done",  F_DONE,  1);
        sb_push("flt_halt",  F_HALT,  0);
        sb_push("flt_state", F_STATE, 2);
        sb_push("flt_head",  F_HEAD,  0);
        sb_push("flt_win",   F_WIN,   32'h020);
        sb_push("flt_cnt",   F_CNT,   exp_cnt(1));
        check_now();

        // Step level held: only one transition per rising edge.
        do_reset();
        load_prog({4{6'h05}}, 32'h0);
        step = 1'b1;
        repeat (10) tick();
        sb_push("step1_head",  F_HEAD,  1);
        sb_push("step1_state", F_STATE, 0);
        sb_push("step1_done",  F_DONE,  0);
        sb_push("step1_cnt",   F_CNT,   exp_cnt(1));
        check_now();
        step = 1'b0;
        repeat (3) tick();
        step = 1'b1;
        repeat (4) tick();
        sb_push("step2_head", F_HEAD, 2);
        sb_push("step2_cnt",  F_CNT,  exp_cnt(2));
        check_now();

        // A rising edge arriving during EXEC is dropped.
        step = 1'b0; tick();
        step = 1'b1; tick();
        step = 1'b0; tick();
        step = 1'b1; tick();
        step = 1'b0;
        repeat (4) tick();
        sb_push("drop_head", F_HEAD, 3);
        sb_push("drop_cnt",  F_CNT,  exp_cnt(3));
        sb_push("drop_win",  F_WIN,  32'h005);
        check_now();

        // Reset during EXEC: outputs clear at once, pending write discarded.
        do_reset();
        load_prog({4{6'h1D}}, 32'h0);
        run = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        sb_push("mid_done",  F_DONE,  0);
        sb_push("mid_ready", F_READY, 1);
        sb_push("mid_head",  F_HEAD,  0);
        sb_push("mid_state", F_STATE, 0);
        check_now();
        run = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        sb_push("mid_win",    F_WIN,   0);
        sb_push("mid_state2", F_STATE, 0);
        sb_push("mid_head2",  F_HEAD,  0);
        check_now();

        // Free-run with stay moves: one transition every 3 cycles.
        load_prog({4{6'h00}}, 32'h0);
        run = 1'b1;
        repeat (300) tick();
        run = 1'b0;
        tick(); tick();
        sb_push("frun_cnt",   F_CNT,   exp_cnt(100));
        sb_push("frun_head",  F_HEAD,  0);
        sb_push("frun_state", F_STATE, 0);
        sb_push("frun_done",  F_DONE,  0);
        sb_push("frun_ready", F_READY, 0);
        check_now();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
